// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data-bus responder: MMIO word offsets, default MMIO base
// and the timer reset values.
package data_bus_responder_pkg;

    localparam logic [3:0] MTIME_LO_OFF     = 4'd0;
    localparam logic [3:0] MTIME_HI_OFF     = 4'd1;
    localparam logic [3:0] MTIMECMP_LO_OFF  = 4'd2;
    localparam logic [3:0] MTIMECMP_HI_OFF  = 4'd3;
    localparam logic [3:0] GPIO_OUT_OFF     = 4'd4;
    localparam logic [3:0] GPIO_IN_OFF      = 4'd5;
    localparam logic [3:0] PRESCALE_CNT_OFF = 4'd6;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0001_0000;

    localparam logic [63:0] MTIME_RST    = 64'h0;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic is_mtime_off(input logic [3:0] off);
        return (off == MTIME_LO_OFF) || (off == MTIME_HI_OFF);
    endfunction

endpackage

// File: rtl/data_bus_responder_mmio_timer.sv
// Machine timer: free-running mtime, mtimecmp, registered level interrupt.
// Optional divider on the mtime increment when TIMER_PRESCALE_EN is defined.
module mmio_timer
    import data_bus_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
`ifdef TIMER_PRESCALE_EN
    , parameter int PRESCALE = 100
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [3:0]                wr_off,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic [2*DATA_WIDTH-1:0]   mtime,
    output logic [2*DATA_WIDTH-1:0]   mtimecmp,
    output logic [DATA_WIDTH-1:0]     prescale_cnt,
    output logic                      timer_irq
);

    localparam int            TW  = 2 * DATA_WIDTH;
    localparam logic [TW-1:0] ONE = TW'(1);

    logic [TW-1:0] mtime_nxt;
    logic [TW-1:0] cmp_nxt;
    logic          tick;
    logic          mtime_wr;

    assign mtime_wr = wr_en && is_mtime_off(wr_off);

`ifdef TIMER_PRESCALE_EN
    localparam int               DIV_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;

    // A software write to mtime restarts the divider so the next tick is a full period away.
    always_comb begin
        tick = (div == DIV_MAX);
        if (mtime_wr || tick)
            div_nxt = '0;
        else
            div_nxt = div + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div <= '0;
        else
            div <= div_nxt;
    end

    assign prescale_cnt = DATA_WIDTH'(div);
`else
    assign tick         = 1'b1;
    assign prescale_cnt = '0;
`endif

    always_comb begin
        mtime_nxt = mtime;
        cmp_nxt   = mtimecmp;
        if (wr_en) begin
            case (wr_off)
                MTIME_LO_OFF:    mtime_nxt[DATA_WIDTH-1:0]  = wr_data;
                MTIME_HI_OFF:    mtime_nxt[TW-1:DATA_WIDTH] = wr_data;
                MTIMECMP_LO_OFF: cmp_nxt[DATA_WIDTH-1:0]    = wr_data;
                MTIMECMP_HI_OFF: cmp_nxt[TW-1:DATA_WIDTH]   = wr_data;
                default: ;
            endcase
        end
        // Software write wins over the increment.
        if (!mtime_wr && tick)
            mtime_nxt = mtime + ONE;
    end

    // irq is computed from next-state values so it tracks the registers in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime     <= TW'(MTIME_RST);
            mtimecmp  <= TW'(MTIMECMP_RST);
            timer_irq <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            mtimecmp  <= cmp_nxt;
            timer_irq <= (mtime_nxt >= cmp_nxt);
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory port responder: word RAM plus MMIO (machine timer, GPIO) with
// combinational reads. Define TIMER_PRESCALE_EN to add the mtime prescaler.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   BUS_WIDTH  = 32,
    parameter int                   RAM_AW     = 10,
    parameter logic [BUS_WIDTH-1:0] MMIO_BASE  = BUS_WIDTH'(MMIO_BASE_DEFAULT),
    parameter int                   GPIO_W     = 8
`ifdef TIMER_PRESCALE_EN
    , parameter int                 PRESCALE   = 100
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ram_we,
    input  logic [BUS_WIDTH-1:0]  ram_address,
    input  logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic [GPIO_W-1:0]     gpio_in,
    output logic [GPIO_W-1:0]     gpio_out,
    output logic                  timer_irq
);

    logic [DATA_WIDTH-1:0]   mem [2**RAM_AW];
    logic                    ram_hit;
    logic                    mmio_hit;
    logic [RAM_AW-1:0]       ram_idx;
    logic [3:0]              mmio_off;
    logic [GPIO_W-1:0]       gpio_meta;
    logic [GPIO_W-1:0]       gpio_sync;
    logic [2*DATA_WIDTH-1:0] mtime;
    logic [2*DATA_WIDTH-1:0] mtimecmp;
    logic [DATA_WIDTH-1:0]   prescale_cnt;
    logic                    unused_byte_bits;

    // Word addressing only: byte-lane bits are ignored.
    assign unused_byte_bits = ^ram_address[1:0];

    assign ram_hit  = (ram_address[BUS_WIDTH-1:RAM_AW+2] == '0);
    assign mmio_hit = (ram_address[BUS_WIDTH-1:6] == MMIO_BASE[BUS_WIDTH-1:6]);
    assign ram_idx  = ram_address[RAM_AW+1:2];
    assign mmio_off = ram_address[5:2];

    always_ff @(posedge clk) begin
        if (ram_we && ram_hit)
            mem[ram_idx] <= ram_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_meta <= '0;
            gpio_sync <= '0;
            gpio_out  <= '0;
        end else begin
            gpio_meta <= gpio_in;
            gpio_sync <= gpio_meta;
            if (ram_we && mmio_hit && (mmio_off == GPIO_OUT_OFF))
                gpio_out <= ram_wdata[GPIO_W-1:0];
        end
    end

    mmio_timer #(
        .DATA_WIDTH(DATA_WIDTH)
`ifdef TIMER_PRESCALE_EN
        , .PRESCALE(PRESCALE)
`endif
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (ram_we && mmio_hit),
        .wr_off       (mmio_off),
        .wr_data      (ram_wdata),
        .mtime        (mtime),
        .mtimecmp     (mtimecmp),
        .prescale_cnt (prescale_cnt),
        .timer_irq    (timer_irq)
    );

    // Zero-latency read mux: the core samples ram_rdata in the same cycle it drives the address.
    always_comb begin
        ram_rdata = '0;
        if (ram_hit) begin
            ram_rdata = mem[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_off)
                MTIME_LO_OFF:     ram_rdata = mtime[DATA_WIDTH-1:0];
                MTIME_HI_OFF:     ram_rdata = mtime[2*DATA_WIDTH-1:DATA_WIDTH];
                MTIMECMP_LO_OFF:  ram_rdata = mtimecmp[DATA_WIDTH-1:0];
                MTIMECMP_HI_OFF:  ram_rdata = mtimecmp[2*DATA_WIDTH-1:DATA_WIDTH];
                GPIO_OUT_OFF:     ram_rdata = DATA_WIDTH'(gpio_out);
                GPIO_IN_OFF:      ram_rdata = DATA_WIDTH'(gpio_sync);
                PRESCALE_CNT_OFF: ram_rdata = prescale_cnt;
                default:          ram_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Randomised bench for data_bus_responder against a behavioural model of the
// memory map, timer and GPIO synchroniser.
module tb_data_bus_responder;

    localparam logic [31:0] MMIO = 32'h0001_0000;
`ifdef TIMER_PRESCALE_EN
    localparam int P = 100;
`else
    localparam int P = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_we;
    logic [31:0] ram_address;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    always #5 clk = ~clk;

    data_bus_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ram_we      (ram_we),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .timer_irq   (timer_irq)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [1024];
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [7:0]  m_gpio_out;
    logic [7:0]  m_s1;
    logic [7:0]  m_s2;
    logic        m_irq;
    int          m_div;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mtime    = 64'd0;
        m_cmp      = 64'hFFFF_FFFF_FFFF_FFFF;
        m_gpio_out = 8'd0;
        m_s1       = 8'd0;
        m_s2       = 8'd0;
        m_irq      = 1'b0;
        m_div      = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int off;
        if (a < 32'h1000) return m_mem[a[11:2]];
        if (a >= MMIO && a < MMIO + 32'h40) begin
            off = int'((a - MMIO) / 4);
            case (off)
                0: return m_mtime[31:0];
                1: return m_mtime[63:32];
                2: return m_cmp[31:0];
                3: return m_cmp[63:32];
                4: return {24'd0, m_gpio_out};
                5: return {24'd0, m_s2};
`ifdef TIMER_PRESCALE_EN
                6: return 32'(m_div);
`endif
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [7:0] gin);
        bit mwr;
        int off;
        mwr = 0;
        if (we && a < 32'h1000) m_mem[a[11:2]] = d;
        if (we && a >= MMIO && a < MMIO + 32'h40) begin
            off = int'((a - MMIO) / 4);
            case (off)
                0: begin m_mtime[31:0]  = d; mwr = 1; end
                1: begin m_mtime[63:32] = d; mwr = 1; end
                2: m_cmp[31:0]  = d;
                3: m_cmp[63:32] = d;
                4: m_gpio_out   = d[7:0];
                default: ;
            endcase
        end
        if (mwr) m_div = 0;
        else if (m_div == P - 1) begin
            m_div   = 0;
            m_mtime = m_mtime + 64'd1;
        end else m_div++;
        m_irq = (m_mtime >= m_cmp);
        m_s2  = m_s1;
        m_s1  = gin;
    endtask

    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
        ram_we      = we;
        ram_address = a;
        ram_wdata   = d;
        @(posedge clk);
        model_edge(we, a, d, gpio_in);
        #1;
        ram_we = 1'b0;
    endtask

    task automatic rd_model(input string tag, input logic [31:0] a);
        ram_we      = 1'b0;
        ram_address = a;
        #1;
        chk(tag, ram_rdata, model_read(a));
    endtask

    task automatic rd_const(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ram_we      = 1'b0;
        ram_address = a;
        #1;
        chk(tag, ram_rdata, exp);
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_irq"},  32'(timer_irq), 32'(m_irq));
        chk({tag, "_gpio"}, 32'(gpio_out),  32'(m_gpio_out));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int kind;

        rst_n       = 1'b0;
        ram_we      = 1'b0;
        ram_address = 32'd0;
        ram_wdata   = 32'd0;
        gpio_in     = 8'd0;
        model_reset();
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq",  32'(timer_irq), 32'd0);
        chk("rst_gpio", 32'(gpio_out),  32'd0);
        rd_const("rst_mtime_lo", MMIO + 32'h0, 32'd0);
        rd_const("rst_cmp_hi",   MMIO + 32'hC, 32'hFFFF_FFFF);
        rd_const("rst_gpio_in",  MMIO + 32'h14, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 1024; i++) cycle(1'b1, 32'(i * 4), 32'd0);

        // RAM write / read, byte offset ignored, neighbour untouched
        cycle(1'b1, 32'h10, 32'hDEAD_BEEF);
        rd_const("ram_rd",      32'h10, 32'hDEAD_BEEF);
        rd_const("ram_rd_byte", 32'h13, 32'hDEAD_BEEF);
        rd_const("ram_rd_next", 32'h14, 32'd0);

        // unmapped write dropped
        cycle(1'b1, 32'h8000, 32'h1234);
        rd_const("unmapped_rd", 32'h8000, 32'd0);
        rd_const("unmapped_ram0", 32'h0, 32'd0);

        // mtime carry from low to high word
        cycle(1'b1, MMIO + 32'h0, 32'hFFFF_FFFE);
        cycle(1'b1, MMIO + 32'h4, 32'h0);
        cycle(1'b0, 32'h0, 32'h0);
        cycle(1'b0, 32'h0, 32'h0);
        rd_model("carry_hi", MMIO + 32'h4);
        rd_model("carry_lo", MMIO + 32'h0);
`ifndef TIMER_PRESCALE_EN
        rd_const("carry_hi_c", MMIO + 32'h4, 32'd1);
        rd_const("carry_lo_c", MMIO + 32'h0, 32'd0);
`endif

        // compare interrupt rise and fall
        cycle(1'b1, MMIO + 32'hC, 32'd0);
        cycle(1'b1, MMIO + 32'h8, 32'd20);
        cycle(1'b1, MMIO + 32'h4, 32'd0);
        cycle(1'b1, MMIO + 32'h0, 32'd0);
        chk("irq_cleared", 32'(timer_irq), 32'(m_irq));
        for (int k = 1; k <= 30; k++) begin
            cycle(1'b0, 32'h0, 32'h0);
            chk("irq_track", 32'(timer_irq), 32'(m_irq));
`ifndef TIMER_PRESCALE_EN
            if (k == 19) chk("irq_low_at19", 32'(timer_irq), 32'd0);
            if (k == 20) chk("irq_high_at20", 32'(timer_irq), 32'd1);
`endif
        end
        cycle(1'b1, MMIO + 32'h8, 32'hFFFF_FFFF);
        chk("irq_fall", 32'(timer_irq), 32'd0);

        // GPIO out and 2-flop input synchroniser
        cycle(1'b1, MMIO + 32'h10, 32'h0000_01A5);
        chk("gpio_out", 32'(gpio_out), 32'h0000_00A5);
        rd_const("gpio_out_rd", MMIO + 32'h10, 32'h0000_00A5);
        gpio_in = 8'h3C;
        cycle(1'b0, 32'h0, 32'h0);
        rd_const("gpio_in_1edge", MMIO + 32'h14, 32'h0);
        cycle(1'b0, 32'h0, 32'h0);
        rd_const("gpio_in_2edge", MMIO + 32'h14, 32'h3C);

        // asynchronous reset in the middle of counting
        cycle(1'b1, MMIO + 32'h8, 32'd10);
        cycle(1'b1, MMIO + 32'h0, 32'd500);
        rd_const("pre_rst_mtime", MMIO + 32'h0, 32'd500);
        chk("pre_rst_irq", 32'(timer_irq), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_irq",  32'(timer_irq), 32'd0);
        chk("mid_rst_gpio", 32'(gpio_out),  32'd0);
        rd_const("mid_rst_mtime", MMIO + 32'h0, 32'd0);
        rd_const("mid_rst_cmp",   MMIO + 32'h8, 32'hFFFF_FFFF);
        rst_n = 1'b1;
        repeat (12) cycle(1'b0, 32'h0, 32'h0);
        rd_model("post_rst_mtime", MMIO + 32'h0);
        rd_model("post_rst_div",   MMIO + 32'h18);
`ifndef TIMER_PRESCALE_EN
        rd_const("post_rst_mtime_c", MMIO + 32'h0, 32'd12);
`endif

        // randomised traffic across all regions
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = 8'($urandom);
            kind = $urandom_range(0, 7);
            d    = $urandom;
            case (kind)
                0, 1, 2: cycle(1'b1, 32'($urandom_range(0, 1023) * 4), d);
                3, 4:    cycle(1'b1, MMIO + 32'($urandom_range(0, 15) * 4), d);
                5:       cycle(1'b1, 32'h0002_0000 + 32'($urandom_range(0, 65535) * 4), d);
                default: cycle(1'b0, 32'($urandom), d);
            endcase
            chk_outs("rnd");
            case ($urandom_range(0, 2))
                0:       a = 32'($urandom_range(0, 1023) * 4) | 32'($urandom_range(0, 3));
                1:       a = MMIO + 32'($urandom_range(0, 15) * 4);
                default: a = 32'h0000_1000 + 32'($urandom_range(0, 4095) * 4);
            endcase
            rd_model("rnd_rd", a);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
